// File: rtl/gpia_port_if.sv
// gpia_port_if: single-cycle Wishbone bus bundle for gpia_port.
//   cyc_i  bus cycle valid           (master -> slave)
//   stb_i  strobe                    (master -> slave)
//   we_i   1 = write, 0 = read       (master -> slave)
//   adr_i  register select, 3 bits   (master -> slave)
//   dat_i  write data, WIDTH bits    (master -> slave)
//   dat_o  registered read data      (slave -> master)
//   ack_o  registered acknowledge    (slave -> master)
interface gpia_port_if #(
  parameter int WIDTH = 16
);
  logic             cyc_i;
  logic             stb_i;
  logic             we_i;
  logic [2:0]       adr_i;
  logic [WIDTH-1:0] dat_i;
  logic [WIDTH-1:0] dat_o;
  logic             ack_o;

  modport slave (
    input  cyc_i, stb_i, we_i, adr_i, dat_i,
    output dat_o, ack_o
  );

  modport master (
    output cyc_i, stb_i, we_i, adr_i, dat_i,
    input  dat_o, ack_o
  );
endinterface

// File: rtl/gpia_port.sv
// gpia_port: WIDTH-bit general-purpose I/O port with synchronised inputs and
// per-bit rising/falling edge interrupts, behind a single-cycle Wishbone slave.
//   clk_i   system clock, all state changes on the rising edge
//   res_i   asynchronous active-low reset
//   bus     Wishbone slave (cyc/stb/we/adr/dat_i in, dat_o/ack_o out)
//   port_i  asynchronous pin inputs
//   port_o  output register (drives the pins directly)
//   irq_o   OR of all pending edge bits
// Register map: 0 OUT, 1 SET, 2 CLR, 3 TGL, 4 IN (read-only),
//               5 PEND (write-1-to-clear), 6 RMASK, 7 FMASK.
module gpia_port #(
  parameter int               WIDTH       = 16,
  parameter int               SYNC_STAGES = 2,
  parameter logic [WIDTH-1:0] OUT_RESET   = '0
) (
  input  logic             clk_i,
  input  logic             res_i,
  gpia_port_if.slave       bus,
  input  logic [WIDTH-1:0] port_i,
  output logic [WIDTH-1:0] port_o,
  output logic             irq_o
);

  localparam logic [2:0] ADR_OUT   = 3'd0;
  localparam logic [2:0] ADR_SET   = 3'd1;
  localparam logic [2:0] ADR_CLR   = 3'd2;
  localparam logic [2:0] ADR_TGL   = 3'd3;
  localparam logic [2:0] ADR_IN    = 3'd4;
  localparam logic [2:0] ADR_PEND  = 3'd5;
  localparam logic [2:0] ADR_RMASK = 3'd6;
  localparam logic [2:0] ADR_FMASK = 3'd7;

  logic [WIDTH-1:0] out_q;
  logic [WIDTH-1:0] out_nxt;
  logic [WIDTH-1:0] pend_q;
  logic [WIDTH-1:0] pend_clr;
  logic [WIDTH-1:0] rmask_q;
  logic [WIDTH-1:0] fmask_q;
  logic [WIDTH-1:0] sync_q [SYNC_STAGES];
  logic [WIDTH-1:0] sync_s;
  logic [WIDTH-1:0] prev_q;
  logic [WIDTH-1:0] rise;
  logic [WIDTH-1:0] fall;
  logic [WIDTH-1:0] rd_data;
  logic [WIDTH-1:0] dat_q;
  logic             ack_q;
  logic             accept;
  logic             wr_en;
  logic             rd_en;

  // A request is taken only while ack is low, so a master holding stb
  // through the ack sees one ack per request with a gap cycle between.
  assign accept = bus.cyc_i & bus.stb_i & ~ack_q;
  assign wr_en  = accept & bus.we_i;
  assign rd_en  = accept & ~bus.we_i;

  // ---- input synchroniser: sync_q[0] captures the pins ----
  always_ff @(posedge clk_i or negedge res_i) begin
    if (!res_i) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
      prev_q <= '0;
    end else begin
      sync_q[0] <= port_i;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
      prev_q <= sync_s;
    end
  end

  assign sync_s = sync_q[SYNC_STAGES-1];

  // ---- edge detect: s against its one-cycle-delayed copy ----
  // Masks gate the edge itself, so enabling a mask never reports an edge
  // that happened while it was disabled.
  assign rise = sync_s & ~prev_q & rmask_q;
  assign fall = ~sync_s & prev_q & fmask_q;

  // New events are OR-ed in after the clear so they win a same-cycle W1C.
  assign pend_clr = (wr_en && bus.adr_i == ADR_PEND) ? bus.dat_i : '0;

  always_comb begin
    out_nxt = out_q;
    if (wr_en) begin
      case (bus.adr_i)
        ADR_OUT: out_nxt = bus.dat_i;
        ADR_SET: out_nxt = out_q | bus.dat_i;
        ADR_CLR: out_nxt = out_q & ~bus.dat_i;
        ADR_TGL: out_nxt = out_q ^ bus.dat_i;
        default: out_nxt = out_q;
      endcase
    end
  end

  always_comb begin
    rd_data = out_q;
    case (bus.adr_i)
      ADR_IN:    rd_data = sync_s;
      ADR_PEND:  rd_data = pend_q;
      ADR_RMASK: rd_data = rmask_q;
      ADR_FMASK: rd_data = fmask_q;
      default:   rd_data = out_q;
    endcase
  end

  // ---- register file and bus response ----
  always_ff @(posedge clk_i or negedge res_i) begin
    if (!res_i) begin
      out_q   <= OUT_RESET;
      pend_q  <= '0;
      rmask_q <= '0;
      fmask_q <= '0;
      dat_q   <= '0;
      ack_q   <= 1'b0;
    end else begin
      out_q  <= out_nxt;
      pend_q <= (pend_q & ~pend_clr) | rise | fall;
      if (wr_en && bus.adr_i == ADR_RMASK) rmask_q <= bus.dat_i;
      if (wr_en && bus.adr_i == ADR_FMASK) fmask_q <= bus.dat_i;
      // dat_o only changes on an accepted read; writes leave it untouched.
      if (rd_en) dat_q <= rd_data;
      ack_q <= accept;
    end
  end

  assign bus.dat_o = dat_q;
  assign bus.ack_o = ack_q;
  assign port_o    = out_q;
  assign irq_o     = |pend_q;

endmodule

// File: doc/gpia_port.md
# gpia_port

Parametrised general-purpose I/O port: WIDTH output bits, WIDTH synchronised input bits, and per-bit edge-detect interrupts behind a single-cycle Wishbone slave. It replaces the single-bit output cell with a full port. The output register keeps the established write/set/clear/toggle semantics, now selected by register address instead of a mode bus. It sits directly on the Kestrel-3 system bus and drives the board GPIO pins and one interrupt line.

## Interface

Parameters:
- WIDTH, 16, number of port bits (1..32).
- SYNC_STAGES, 2, input synchroniser depth (≥2).
- OUT_RESET, 0, reset value of the output register (WIDTH bits).

Ports:
- clk_i  in  1  system clock; all state changes on the rising edge.
- res_i  in  1  reset; asynchronous, active-low.
- cyc_i  in  1  bus cycle valid.
- stb_i  in  1  strobe.
- we_i  in  1  1 = write, 0 = read.
- adr_i  in  3  register select.
- dat_i  in  WIDTH  write data.
- dat_o  out  WIDTH  read data (registered).
- ack_o  out  1  transfer acknowledge (registered).
- port_i  in  WIDTH  asynchronous pin inputs.
- port_o  out  WIDTH  output register.
- irq_o  out  1  OR of all pending edge bits.

## Operation

Register map (adr_i):
- 0 OUT: write sets OUT := dat_i. Read returns OUT.
- 1 SET: write sets OUT := OUT | dat_i. Read returns OUT.
- 2 CLR: write sets OUT := OUT & ~dat_i. Read returns OUT.
- 3 TGL: write sets OUT := OUT ^ dat_i. Read returns OUT.
- 4 IN: read returns the last synchroniser stage. Writes are ignored but still acknowledged.
- 5 PEND: read returns pending edges. A write is write-1-to-clear.
- 6 RMASK: read/write rising-edge enable mask.
- 7 FMASK: read/write falling-edge enable mask.

Datapath behaviour:
- port_o is the OUT register itself; no combinational path from the bus to the pins.
- Synchroniser: SYNC_STAGES flops per bit. s is the last stage; p is s delayed one cycle.
- rise = s & ~p & RMASK; fall = ~s & p & FMASK.
- Pending update: PEND := (PEND & ~clr) | rise | fall. clr = dat_i on a PEND write, else 0.
- A new event wins over a simultaneous W1C of the same bit.
- irq_o = |PEND (combinational from the PEND register only).
- Changing a mask never retroactively sets PEND. Only edges observed while the mask bit is 1 latch.

Reset (res_i low, immediate, independent of clk_i):
- OUT = OUT_RESET.
- PEND, RMASK, FMASK, synchroniser stages, p, dat_o, ack_o = 0.
- Hence port_o = OUT_RESET and irq_o = 0.
- Reset asserted mid-transfer aborts the transfer: ack_o drops at once and any pending write is lost.

## Timing

Bus accept:
- A request is accepted on a rising edge where cyc_i & stb_i & ~ack_o.
- At that same edge: the write (if any) updates its register, dat_o loads the read data, and ack_o goes 1.
- Write data is visible on port_o and on reads from the next cycle.
- ack_o is 1 for exactly one cycle, then 0 for at least one cycle.
- Each access therefore takes 2 cycles. A master holding stb_i through ack gets exactly one ack per request.
- dat_o holds its value until the next accepted read. It is don't-care on writes, and the implementation holds its previous value.
- Dropping cyc_i or stb_i before the accept edge cancels the request with no side effects.

Input path:
- port_i changes and is captured at edge E0.
- IN reads reflect it from E0+SYNC_STAGES-1.
- PEND and irq_o assert after edge E0+SYNC_STAGES.
- Pulses shorter than one clock may be missed; no guarantee is given for them.

## Test plan

WIDTH=8, SYNC_STAGES=2, OUT_RESET=0 unless noted.

1. Reset: res_i low with port_i=FF -> port_o=00, irq_o=0, ack_o=0. After release, a read of adr 4 returns FF and a read of adr 5 returns 00. Repeat with OUT_RESET=A5 and check port_o=A5.
2. Output modes: write adr0=5A, adr1=81, adr2=18, adr3=FF -> port_o after each is 5A, DB, C3, 3C. Reads of adr0-3 return 3C. Each ack_o lasts one cycle.
3. Handshake: hold cyc_i/stb_i high with we_i=1, adr1, dat_i=01 for 6 cycles -> acks land on cycles 1, 3, 5. port_o=01 (idempotent set). A strobe withdrawn before its edge produces no ack and no change.
4. Edges: RMASK=01, FMASK=02; drive port_i bit0 0→1 and bit1 1→0 -> PEND=03 and irq_o=1 exactly 2 edges after capture. Bit2 toggling with masks 0 leaves PEND unchanged.
5. W1C race: PEND=01, then write adr5=01 on the same edge a new bit0 rise latches -> PEND stays 01. A later write adr5=01 -> PEND=00, irq_o=0.
6. Async reset mid-transfer: assert res_i between accept edge and ack -> ack_o=0 immediately, and after release port_o=OUT_RESET.
